plru_ctrl: RTL and testbench

//  Initiator side of the per-set 2-way PLRU array port (csb0/web0/addr0/din0/dout0).

---
 rtl/plru_ctrl.sv | 140 ++++++++++++++
 tb/tb_plru_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plru_ctrl.sv
// plru_ctrl: arbitrates PLRU touch writes and victim reads onto a single-port 2-way PLRU array.
// Define PLRU_CTRL_PERF_EN to add saturating perf_touch / perf_vic counters.
module plru_ctrl #(
  parameter int S_INDEX = 4,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_valid,
  input  logic [S_INDEX-1:0] upd_set,
  input  logic               upd_way,
  output logic               upd_ready,
  input  logic               vic_req,
  input  logic [S_INDEX-1:0] vic_set,
  output logic               vic_valid,
  output logic               vic_way,
  output logic               csb0,
  output logic               web0,
  output logic [S_INDEX-1:0] addr0,
  output logic               din0,
  input  logic               dout0
`ifdef PLRU_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_touch,
  output logic [31:0]        perf_vic
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic       r_vic_way;
  logic       w_vic_way_nxt;
  logic       w_port_free;

  // State, latency counter and captured victim way
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_vic_way <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_vic_way <= w_vic_way_nxt;
    end
  end

  // Next-state logic; touches win over victim reads whenever the port is free
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_vic_way_nxt = r_vic_way;
    w_port_free   = 1'b0;
    case (r_state)
      IDLE: begin
        w_port_free = 1'b1;
        if (!upd_valid && vic_req) begin
          w_state_nxt = RD_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (r_cnt != 2'd0) begin
          w_cnt_nxt = r_cnt - 2'd1;
        end else begin
          w_vic_way_nxt = dout0;
          w_state_nxt   = RESP;
        end
      end
      RESP: begin
        w_port_free = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Array port drive; reset forces the port idle even mid-cycle
  always_comb begin
    upd_ready = 1'b0;
    csb0      = 1'b1;
    web0      = 1'b1;
    addr0     = {S_INDEX{1'b0}};
    din0      = 1'b0;
    if (!rst && w_port_free && upd_valid) begin
      upd_ready = 1'b1;
      csb0      = 1'b0;
      web0      = 1'b0;
      addr0     = upd_set;
      din0      = upd_way;
    end else if (!rst && (r_state == IDLE) && vic_req) begin
      csb0  = 1'b0;
      web0  = 1'b1;
      addr0 = vic_set;
    end else begin
      csb0 = 1'b1;
    end
  end

  assign vic_valid = (r_state == RESP);
  assign vic_way   = r_vic_way;

`ifdef PLRU_CTRL_PERF_EN
  logic [31:0] r_perf_touch;
  logic [31:0] r_perf_vic;

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_touch <= 32'd0;
      r_perf_vic   <= 32'd0;
    end else begin
      if (upd_ready && (r_perf_touch != 32'hFFFF_FFFF)) begin
        r_perf_touch <= r_perf_touch + 32'd1;
      end
      if (vic_valid && (r_perf_vic != 32'hFFFF_FFFF)) begin
        r_perf_vic <= r_perf_vic + 32'd1;
      end
    end
  end

  assign perf_touch = r_perf_touch;
  assign perf_vic   = r_perf_vic;
`endif

endmodule

// File: tb/tb_plru_ctrl.sv
// Bench for plru_ctrl: two instances (RD_LAT=1 and RD_LAT=3), each with an array model and a
// cycle-schedule reference model, plus directed vectors with literal expectations.
module tb_plru_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid [2];
  logic [3:0]  upd_set   [2];
  logic        upd_way   [2];
  logic        upd_ready [2];
  logic        vic_req   [2];
  logic [3:0]  vic_set   [2];
  logic        vic_valid [2];
  logic        vic_way   [2];
  logic        csb0      [2];
  logic        web0      [2];
  logic [3:0]  addr0     [2];
  logic        din0      [2];
  logic        dout0     [2];
`ifdef PLRU_CTRL_PERF_EN
  logic [31:0] perf_touch [2];
  logic [31:0] perf_vic   [2];
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s inst%0d at cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int LAT = (g == 0) ? 1 : 3;

    plru_ctrl #(.S_INDEX(4), .RD_LAT(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .upd_valid (upd_valid[g]),
      .upd_set   (upd_set[g]),
      .upd_way   (upd_way[g]),
      .upd_ready (upd_ready[g]),
      .vic_req   (vic_req[g]),
      .vic_set   (vic_set[g]),
      .vic_valid (vic_valid[g]),
      .vic_way   (vic_way[g]),
      .csb0      (csb0[g]),
      .web0      (web0[g]),
      .addr0     (addr0[g]),
      .din0      (din0[g]),
      .dout0     (dout0[g])
`ifdef PLRU_CTRL_PERF_EN
      ,
      .perf_touch (perf_touch[g]),
      .perf_vic   (perf_vic[g])
`endif
    );

    // Array: stores MRU way, returns LRU (= ~MRU) LAT cycles after the read edge.
    // Non-read slots carry the complement of the last read so mistimed captures show up.
    logic mem  [16]  = '{default: 1'b0};
    logic pipe [LAT] = '{default: 1'b0};
    logic last_rd    = 1'b0;

    always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      if (!csb0[g] && web0[g]) begin
        pipe[0] <= ~mem[addr0[g]];
        last_rd <= ~mem[addr0[g]];
      end else begin
        pipe[0] <= ~last_rd;
      end
      if (!csb0[g] && !web0[g]) mem[addr0[g]] <= din0[g];
    end

    assign dout0[g] = pipe[LAT-1];

    // Reference: a read issued in cycle c responds in cycle c+LAT+1, port busy in between
    int          issue   = -1;
    logic        pend    = 1'b0;
    logic        m_way   = 1'b0;
    logic        ref_mru [16] = '{default: 1'b0};
    int unsigned touches = 0;
    int unsigned vics    = 0;
    logic        busy, resp, rd, e_ready;

    initial forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ready", g, 32'(upd_ready[g]), 32'd0);
        chk("rst_csb0", g, 32'(csb0[g]), 32'd1);
        chk("rst_web0", g, 32'(web0[g]), 32'd1);
        chk("rst_addr0", g, 32'(addr0[g]), 32'd0);
        chk("rst_din0", g, 32'(din0[g]), 32'd0);
        chk("rst_vic_valid", g, 32'(vic_valid[g]), 32'd0);
        chk("rst_vic_way", g, 32'(vic_way[g]), 32'd0);
`ifdef PLRU_CTRL_PERF_EN
        chk("rst_perf_touch", g, perf_touch[g], 32'd0);
        chk("rst_perf_vic", g, perf_vic[g], 32'd0);
`endif
        issue   = -1;
        m_way   = 1'b0;
        touches = 0;
        vics    = 0;
      end else begin
        resp    = (issue >= 0) && (cyc == issue + LAT + 1);
        busy    = (issue >= 0) && (cyc > issue) && (cyc < issue + LAT + 1);
        e_ready = !busy && upd_valid[g];
        rd      = !busy && !resp && !upd_valid[g] && vic_req[g];
        if (resp) m_way = pend;
        chk("m_ready", g, 32'(upd_ready[g]), 32'(e_ready));
        chk("m_csb0", g, 32'(csb0[g]), 32'(!(e_ready || rd)));
        chk("m_web0", g, 32'(web0[g]), 32'(!e_ready));
        chk("m_addr0", g, 32'(addr0[g]), e_ready ? 32'(upd_set[g]) : (rd ? 32'(vic_set[g]) : 32'd0));
        chk("m_din0", g, 32'(din0[g]), e_ready ? 32'(upd_way[g]) : 32'd0);
        chk("m_vic_valid", g, 32'(vic_valid[g]), 32'(resp));
        chk("m_vic_way", g, 32'(vic_way[g]), 32'(m_way));
`ifdef PLRU_CTRL_PERF_EN
        chk("m_perf_touch", g, perf_touch[g], touches);
        chk("m_perf_vic", g, perf_vic[g], vics);
`endif
        if (e_ready) begin
          ref_mru[upd_set[g]] = upd_way[g];
          if (touches != 32'hFFFF_FFFF) touches++;
        end
        if (rd) begin
          issue = cyc;
          pend  = ~ref_mru[vic_set[g]];
        end
        if (resp && (vics != 32'hFFFF_FFFF)) vics++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_step(input bit allow_new);
    logic seen [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) seen[k] = vic_valid[k];
    tick();
    for (int k = 0; k < 2; k++) begin
      if (vic_req[k]) begin
        if (seen[k]) vic_req[k] = 1'b0;
      end else if (allow_new && ($urandom_range(0, 3) == 0)) begin
        vic_req[k] = 1'b1;
        vic_set[k] = 4'($urandom_range(0, 15));
      end
      upd_valid[k] = allow_new && ($urandom_range(0, 2) == 0);
      upd_set[k]   = 4'($urandom_range(0, 15));
      upd_way[k]   = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int lat;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      upd_valid[k] = 1'b0;
      upd_set[k]   = 4'h0;
      upd_way[k]   = 1'b0;
      vic_req[k]   = 1'b0;
      vic_set[k]   = 4'h0;
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset asserted mid-cycle drops a pending touch immediately
    upd_valid[0] = 1'b1; upd_set[0] = 4'h5; upd_way[0] = 1'b1;
    #2;
    chk("t1_ready_pre", 0, 32'(upd_ready[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_ready", 0, 32'(upd_ready[0]), 32'd0);
    chk("t1_csb0", 0, 32'(csb0[0]), 32'd1);
    chk("t1_web0", 0, 32'(web0[0]), 32'd1);
    chk("t1_addr0", 0, 32'(addr0[0]), 32'd0);
    chk("t1_din0", 0, 32'(din0[0]), 32'd0);
    chk("t1_vic_valid", 0, 32'(vic_valid[0]), 32'd0);
    tick();
    rst = 1'b0;
    upd_valid[0] = 1'b0;

    // Touch in IDLE
    upd_valid[0] = 1'b1; upd_set[0] = 4'h3; upd_way[0] = 1'b1;
    @(negedge clk);
    chk("t2_ready", 0, 32'(upd_ready[0]), 32'd1);
    chk("t2_csb0", 0, 32'(csb0[0]), 32'd0);
    chk("t2_web0", 0, 32'(web0[0]), 32'd0);
    chk("t2_addr0", 0, 32'(addr0[0]), 32'd3);
    chk("t2_din0", 0, 32'(din0[0]), 32'd1);
    tick();
    upd_valid[0] = 1'b0;

    // Victim read, RD_LAT=1: response two cycles after issue
    vic_req[0] = 1'b1; vic_set[0] = 4'h3;
    @(negedge clk);
    chk("t3_rd_csb0", 0, 32'(csb0[0]), 32'd0);
    chk("t3_rd_web0", 0, 32'(web0[0]), 32'd1);
    chk("t3_rd_addr0", 0, 32'(addr0[0]), 32'd3);
    tick();
    @(negedge clk);
    chk("t3_wait_valid", 0, 32'(vic_valid[0]), 32'd0);
    chk("t3_wait_csb0", 0, 32'(csb0[0]), 32'd1);
    tick();
    @(negedge clk);
    chk("t3_valid", 0, 32'(vic_valid[0]), 32'd1);
    chk("t3_way", 0, 32'(vic_way[0]), 32'd0);
    tick();
    vic_req[0] = 1'b0;
    @(negedge clk);
    chk("t3_idle_valid", 0, 32'(vic_valid[0]), 32'd0);
    tick();

    // Collision: write first, read next cycle
    upd_valid[0] = 1'b1; upd_set[0] = 4'h7; upd_way[0] = 1'b1;
    vic_req[0] = 1'b1; vic_set[0] = 4'h7;
    @(negedge clk);
    chk("t4_wr_ready", 0, 32'(upd_ready[0]), 32'd1);
    chk("t4_wr_web0", 0, 32'(web0[0]), 32'd0);
    chk("t4_wr_addr0", 0, 32'(addr0[0]), 32'd7);
    tick();
    upd_valid[0] = 1'b0;
    @(negedge clk);
    chk("t4_rd_csb0", 0, 32'(csb0[0]), 32'd0);
    chk("t4_rd_web0", 0, 32'(web0[0]), 32'd1);
    tick();
    @(negedge clk);
    chk("t4_wait_valid", 0, 32'(vic_valid[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("t4_valid", 0, 32'(vic_valid[0]), 32'd1);
    chk("t4_way", 0, 32'(vic_way[0]), 32'd0);
    tick();
    vic_req[0] = 1'b0;

    // Stalled touch accepted in RESP; following read sees the fill
    vic_req[0] = 1'b1; vic_set[0] = 4'h3;
    @(negedge clk);
    chk("t5_rd_csb0", 0, 32'(csb0[0]), 32'd0);
    tick();
    upd_valid[0] = 1'b1; upd_set[0] = 4'h3; upd_way[0] = 1'b0;
    @(negedge clk);
    chk("t5_stall_ready", 0, 32'(upd_ready[0]), 32'd0);
    chk("t5_stall_csb0", 0, 32'(csb0[0]), 32'd1);
    tick();
    @(negedge clk);
    chk("t5_resp_valid", 0, 32'(vic_valid[0]), 32'd1);
    chk("t5_resp_way", 0, 32'(vic_way[0]), 32'd0);
    chk("t5_fill_ready", 0, 32'(upd_ready[0]), 32'd1);
    chk("t5_fill_web0", 0, 32'(web0[0]), 32'd0);
    chk("t5_fill_din0", 0, 32'(din0[0]), 32'd0);
    tick();
    upd_valid[0] = 1'b0; vic_req[0] = 1'b0;
    @(negedge clk);
    chk("t5_idle_csb0", 0, 32'(csb0[0]), 32'd1);
    tick();
    vic_req[0] = 1'b1; vic_set[0] = 4'h3;
    tick();
    tick();
    @(negedge clk);
    chk("t5_raw_valid", 0, 32'(vic_valid[0]), 32'd1);
    chk("t5_raw_way", 0, 32'(vic_way[0]), 32'd1);
    tick();
    vic_req[0] = 1'b0;

    // Reset during RD_WAIT with RD_LAT=3 drops the read
    vic_req[1] = 1'b1; vic_set[1] = 4'h3;
    @(negedge clk);
    chk("t6_rd_csb0", 1, 32'(csb0[1]), 32'd0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    vic_req[1] = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
`ifdef PLRU_CTRL_PERF_EN
    chk("t6_perf_touch", 1, perf_touch[1], 32'd0);
    chk("t6_perf_vic", 1, perf_vic[1], 32'd0);
    chk("t6_perf_touch0", 0, perf_touch[0], 32'd0);
`endif
    for (int n = 0; n < 5; n++) begin
      if (n != 0) @(negedge clk);
      chk("t6_no_valid", 1, 32'(vic_valid[1]), 32'd0);
      tick();
    end

    // RD_LAT=3 latency: issue to vic_valid is four cycles
    vic_req[1] = 1'b1; vic_set[1] = 4'h9;
    lat = -1;
    for (int n = 0; n < 10 && lat < 0; n++) begin
      @(negedge clk);
      if (vic_valid[1]) lat = n;
      else tick();
    end
    chk("t7_latency", 1, 32'(lat), 32'd4);
    chk("t7_way", 1, 32'(vic_way[1]), 32'd1);
    tick();
    vic_req[1] = 1'b0;

    // Mixed traffic on both instances, then drain
    repeat (80) rand_step(1'b1);
    repeat (12) rand_step(1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
